// File: rtl/conv_ctrl_gen.sv
// rtl/conv_ctrl_gen.sv - runtime-configurable KxK convolution DRAM sequencer
//
// Purpose: fetches layer parameters, validates them, then walks kernels,
// input-map windows (full and shift-in) and output partial-sum
// read-modify-write for every input channel of one layer.
// Ports:
//   clk, srstn           clock, asynchronous active-low reset
//   start, mem_stall     layer start pulse, DRAM not-ready freeze
//   data_in              DRAM read data (cycle after an unstalled read)
//   addr_in/addr_out     DRAM read/write address
//   dram_en_rd/wr        read/write strobes
//   busy, done, err      handshake and parameter-error flag
//   en_ld_knl, en_ld_ifmap, ifmap_shift, psum_first   datapath qualifiers
//   num_knls, knl_dim    latched kernel count and kernel dimension
//   cnt_ofmap_chnl_ff    output channel of the current write
module conv_ctrl_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int DIM_WIDTH  = 5,
  parameter int CHNL_WIDTH = 4,
  parameter int KNL_MAX    = 7,
  parameter int PARAM_BASE = 0,
  parameter int WTS_BASE   = 64,
  parameter int IFMAP_BASE = 65536,
  parameter int OFMAP_BASE = 131072
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  start,
  input  logic                  mem_stall,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  dram_en_rd,
  output logic                  dram_en_wr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  en_ld_knl,
  output logic                  en_ld_ifmap,
  output logic                  ifmap_shift,
  output logic                  psum_first,
  output logic [CHNL_WIDTH:0]   num_knls,
  output logic [2:0]            knl_dim,
  output logic [CHNL_WIDTH-1:0] cnt_ofmap_chnl_ff
);
  localparam int AW  = ADDR_WIDTH;
  localparam int CW1 = CHNL_WIDTH + 1;
  localparam int CNW = CHNL_WIDTH + 2;
  localparam int DW1 = DIM_WIDTH + 1;
  localparam int DW2 = DIM_WIDTH + 2;

  localparam logic [2:0] IDLE          = 3'd0;
  localparam logic [2:0] LD_PARAM      = 3'd1;
  localparam logic [2:0] CHECK         = 3'd2;
  localparam logic [2:0] LD_KNLS       = 3'd3;
  localparam logic [2:0] LD_IFMAP_FULL = 3'd4;
  localparam logic [2:0] LD_IFMAP_PART = 3'd5;
  localparam logic [2:0] CONV          = 3'd6;
  localparam logic [2:0] DONE          = 3'd7;

  logic [2:0]       state;
  logic [6:0]       cnt_in;   // param word / weight index / dy
  logic [CNW-1:0]   cnt_out;  // kernel id / dx / CONV cycle
  logic [CW1-1:0]   chnl, depth;
  logic [DW1-1:0]   height, width, base_x, base_y;
  logic [1:0]       stride;
  logic             param_vld;
  logic [2:0]       param_idx;

  logic [5:0]       kk;
  logic [6:0]       kk_last;
  logic [2:0]       k_last;
  logic [CNW-1:0]   nk_ext, knl_last, wr_ochnl;
  logic [DW1-1:0]   pix_x, pix_y, ox, oy;
  logic [DW2-1:0]   x_end, y_end;
  logic             param_bad, rd_req, wr_req;
  logic [AW-1:0]    rd_addr, wr_addr;
  logic             unused_ok;

  assign kk       = 6'(knl_dim) * 6'(knl_dim);
  assign kk_last  = {1'b0, kk} - 7'd1;
  assign k_last   = knl_dim - 3'd1;
  assign nk_ext   = {1'b0, num_knls};
  assign knl_last = nk_ext - CNW'(1);
  assign wr_ochnl = cnt_out - CNW'(1);
  assign pix_y    = base_y + DW1'(cnt_in);
  assign pix_x    = base_x + DW1'(cnt_out);
  // Output coordinates: stride is 1 or 2 once validated.
  assign oy       = (stride == 2'd2) ? (base_y >> 1) : base_y;
  assign ox       = (stride == 2'd2) ? (base_x >> 1) : base_x;
  assign x_end    = DW2'(base_x) + DW2'(stride) + DW2'(knl_dim);
  assign y_end    = DW2'(base_y) + DW2'(stride) + DW2'(knl_dim);

  assign param_bad = (knl_dim == 3'd0) || (32'(knl_dim) > KNL_MAX) ||
                     ((stride != 2'd1) && (stride != 2'd2)) ||
                     (DW1'(knl_dim) > height) || (DW1'(knl_dim) > width) ||
                     (num_knls == '0) || (depth == '0) ||
                     (32'(num_knls) > (1 << CHNL_WIDTH)) ||
                     (32'(depth) > (1 << CHNL_WIDTH));

  always_comb begin
    rd_req  = 1'b0;
    rd_addr = '0;
    case (state)
      LD_PARAM: begin
        rd_req  = (cnt_in < 7'd6);
        rd_addr = AW'(PARAM_BASE) + AW'(cnt_in);
      end
      LD_KNLS: begin
        rd_req  = 1'b1;
        rd_addr = AW'(WTS_BASE) +
                  AW'({cnt_out[CHNL_WIDTH-1:0], chnl[CHNL_WIDTH-1:0], cnt_in[5:0]});
      end
      LD_IFMAP_FULL, LD_IFMAP_PART: begin
        rd_req  = 1'b1;
        rd_addr = AW'(IFMAP_BASE) +
                  AW'({chnl[CHNL_WIDTH-1:0], pix_y[DIM_WIDTH-1:0], pix_x[DIM_WIDTH-1:0]});
      end
      CONV: begin
        rd_req  = (cnt_out < nk_ext);
        rd_addr = AW'(OFMAP_BASE) +
                  AW'({cnt_out[CHNL_WIDTH-1:0], oy[DIM_WIDTH-1:0], ox[DIM_WIDTH-1:0]});
      end
      default: ;
    endcase
  end

  // Write of cycle i targets the psum read in cycle i-1.
  assign wr_req  = (state == CONV) && (cnt_out != '0);
  assign wr_addr = AW'(OFMAP_BASE) +
                   AW'({wr_ochnl[CHNL_WIDTH-1:0], oy[DIM_WIDTH-1:0], ox[DIM_WIDTH-1:0]});

  assign dram_en_rd        = rd_req && !mem_stall;
  assign dram_en_wr        = wr_req && !mem_stall;
  assign addr_in           = rd_req ? rd_addr : '0;
  assign addr_out          = wr_req ? wr_addr : '0;
  assign cnt_ofmap_chnl_ff = wr_req ? wr_ochnl[CHNL_WIDTH-1:0] : '0;
  assign psum_first        = (state == CONV) && (chnl == '0);
  assign busy              = (state != IDLE) && (state != DONE);
  assign done              = (state == DONE);
  assign unused_ok = &{1'b0, data_in, pix_x[DIM_WIDTH], pix_y[DIM_WIDTH],
                       ox[DIM_WIDTH], oy[DIM_WIDTH], wr_ochnl[CNW-1:CHNL_WIDTH]};

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state       <= IDLE;
      cnt_in      <= '0;
      cnt_out     <= '0;
      chnl        <= '0;
      base_x      <= '0;
      base_y      <= '0;
      num_knls    <= '0;
      depth       <= '0;
      height      <= '0;
      width       <= '0;
      knl_dim     <= '0;
      stride      <= '0;
      err         <= 1'b0;
      en_ld_knl   <= 1'b0;
      en_ld_ifmap <= 1'b0;
      ifmap_shift <= 1'b0;
      param_vld   <= 1'b0;
      param_idx   <= '0;
    end else begin
      // Load qualifiers follow issued reads even through a stall: the word
      // of an issued read always arrives on the next cycle.
      en_ld_knl   <= dram_en_rd && (state == LD_KNLS);
      en_ld_ifmap <= dram_en_rd && ((state == LD_IFMAP_FULL) || (state == LD_IFMAP_PART));
      ifmap_shift <= dram_en_rd && (state == LD_IFMAP_PART);
      param_vld   <= dram_en_rd && (state == LD_PARAM);
      param_idx   <= cnt_in[2:0];
      if (param_vld) begin
        case (param_idx)
          3'd0: num_knls <= data_in[CHNL_WIDTH:0];
          3'd1: depth    <= data_in[CHNL_WIDTH:0];
          3'd2: height   <= data_in[DIM_WIDTH:0];
          3'd3: width    <= data_in[DIM_WIDTH:0];
          3'd4: knl_dim  <= data_in[2:0];
          3'd5: stride   <= data_in[1:0];
          default: ;
        endcase
      end
      case (state)
        IDLE: if (start) begin
          state   <= LD_PARAM;
          err     <= 1'b0;
          cnt_in  <= '0;
          cnt_out <= '0;
          chnl    <= '0;
          base_x  <= '0;
          base_y  <= '0;
        end
        DONE: state <= IDLE;
        default: if (!mem_stall) begin
          case (state)
            LD_PARAM: begin
              // Word 5 is latched on the same edge that enters CHECK.
              if (cnt_in == 7'd6) begin
                state  <= CHECK;
                cnt_in <= '0;
              end else begin
                cnt_in <= cnt_in + 7'd1;
              end
            end
            CHECK: begin
              cnt_in  <= '0;
              cnt_out <= '0;
              if (param_bad) begin
                state <= DONE;
                err   <= 1'b1;
              end else begin
                state <= LD_KNLS;
              end
            end
            LD_KNLS: begin
              if (cnt_in == kk_last) begin
                cnt_in <= '0;
                if (cnt_out == knl_last) begin
                  cnt_out <= '0;
                  base_x  <= '0;
                  base_y  <= '0;
                  state   <= LD_IFMAP_FULL;
                end else begin
                  cnt_out <= cnt_out + CNW'(1);
                end
              end else begin
                cnt_in <= cnt_in + 7'd1;
              end
            end
            LD_IFMAP_FULL, LD_IFMAP_PART: begin
              if (cnt_in == 7'(k_last)) begin
                cnt_in <= '0;
                if (cnt_out == CNW'(k_last)) begin
                  cnt_out <= '0;
                  state   <= CONV;
                end else begin
                  cnt_out <= cnt_out + CNW'(1);
                end
              end else begin
                cnt_in <= cnt_in + 7'd1;
              end
            end
            CONV: begin
              if (cnt_out == nk_ext) begin
                cnt_in <= '0;
                if (x_end <= DW2'(width)) begin
                  base_x  <= base_x + DW1'(stride);
                  cnt_out <= CNW'(knl_dim) - CNW'(stride);
                  state   <= LD_IFMAP_PART;
                end else if (y_end <= DW2'(height)) begin
                  base_x  <= '0;
                  base_y  <= base_y + DW1'(stride);
                  cnt_out <= '0;
                  state   <= LD_IFMAP_FULL;
                end else if ((chnl + CW1'(1)) < depth) begin
                  chnl    <= chnl + CW1'(1);
                  base_x  <= '0;
                  base_y  <= '0;
                  cnt_out <= '0;
                  state   <= LD_KNLS;
                end else begin
                  cnt_out <= '0;
                  state   <= DONE;
                end
              end else begin
                cnt_out <= cnt_out + CNW'(1);
              end
            end
            default: ;
          endcase
        end
      endcase
    end
  end
endmodule
